instr_rom_stim: RTL and testbench



---
 rtl/instr_rom_stim_pkg.sv | 19 +
 rtl/instr_rom_stim_if.sv | 30 +++
 rtl/instr_rom_stim_pipe.sv | 46 ++++
 rtl/instr_rom_stim.sv | 185 ++++++++++++++++++
 tb/tb_instr_rom_stim.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_rom_stim_pkg.sv
// Shared types and constants for the instruction-ROM stimulus block.
package instr_rom_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [31:0] RV_NOP       = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RV_EBREAK    = 32'h0010_0073;  // ebreak
  localparam int          MAX_READ_LAT = 3;

  // A fetch is out of range when it is misaligned or points past the image.
  function automatic logic pc_oob(input logic [31:0] pc, input int unsigned aw);
    return ((pc >> (aw + 32'd2)) != 32'd0) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_rom_stim_if.sv
// Program-load, control and fetch bus between the bench top / core and
// the instruction-ROM stimulus block.
interface instr_rom_stim_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 8,
  parameter int CW     = 16
);
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              start;
  logic [31:0]       IFPC;
  logic [DATA_W-1:0] ROMData;
  logic              rom_valid;
  logic              core_rst_n;
  logic              done;
  logic              timeout;
  logic              oob;
  logic [CW-1:0]     cycle_cnt;

  modport master (
    output prog_we, prog_addr, prog_data, start, IFPC,
    input  ROMData, rom_valid, core_rst_n, done, timeout, oob, cycle_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, IFPC,
    output ROMData, rom_valid, core_rst_n, done, timeout, oob, cycle_cnt
  );
endinterface

// File: rtl/instr_rom_stim_pipe.sv
// LAT-deep data+valid delay line. LAT=0 is a plain pass-through; otherwise
// flush_i synchronously clears every stage to FILL / not-valid.
module instr_rom_stim_pipe #(
  parameter int               WIDTH = 32,
  parameter int               LAT   = 1,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic             clk,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  if (LAT == 0) begin : g_pass
    logic unused_s;
    assign unused_s = &{1'b0, clk, flush_i};
    assign data_o   = data_i;
    assign valid_o  = valid_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q  [LAT];
    logic             valid_q [LAT];

    // Shift data and valid one stage per clock, or clear all stages on flush.
    always_ff @(posedge clk) begin
      if (flush_i) begin
        for (int i = 0; i < LAT; i++) begin
          data_q[i]  <= FILL;
          valid_q[i] <= 1'b0;
        end
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int i = 1; i < LAT; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign data_o  = data_q[LAT-1];
    assign valid_o = valid_q[LAT-1];
  end

endmodule

// File: rtl/instr_rom_stim.sv
// Instruction-fetch stimulus for RISCVCore benches: preloadable program
// image, READ_LAT-cycle fetch path, core reset control, and run termination
// on a halt word or after MAX_CYCLES run cycles.
// Optional trace outputs (last_pc, fetch_cnt) exist only when the macro
// INSTR_ROM_STIM_TRACE_EN is defined.
module instr_rom_stim
  import instr_rom_stim_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 256,
  parameter int                AW         = $clog2(DEPTH),
  parameter int                READ_LAT   = 1,
  parameter logic [DATA_W-1:0] FILL_WORD  = RV_NOP,
  parameter logic [DATA_W-1:0] HALT_WORD  = RV_EBREAK,
  parameter int                MAX_CYCLES = 1024,
  parameter int                CW         = 16
) (
  input  logic              CLK,
  input  logic              rst,
  instr_rom_stim_if.slave   bus
`ifdef INSTR_ROM_STIM_TRACE_EN
  ,
  output logic [31:0]       last_pc,
  output logic [CW-1:0]     fetch_cnt
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              core_rst_n_q, done_q, timeout_q, oob_q;
  logic [CW-1:0]     cycle_cnt_q;

  logic              run_s;
  logic [AW-1:0]     fetch_idx_s;
  logic              fetch_oob_s;
  logic [DATA_W-1:0] word_in_s;
  logic [DATA_W-1:0] word_out_s;
  logic              valid_out_s;
  logic              halt_hit_s;
  logic              timeout_hit_s;
  logic              flush_s;

  assign run_s       = (state_q == RUN);
  assign fetch_idx_s = bus.IFPC[AW+1:2];
  assign fetch_oob_s = pc_oob(bus.IFPC, AW);

  // Fetch word: the addressed entry, or FILL when out of range or not running.
  always_comb begin
    word_in_s = FILL_WORD;
    if (run_s && !fetch_oob_s) begin
      word_in_s = mem_q[fetch_idx_s];
    end else begin
      word_in_s = FILL_WORD;
    end
  end

  assign halt_hit_s    = run_s && valid_out_s && (word_out_s == HALT_WORD);
  assign timeout_hit_s = run_s && (cycle_cnt_q == CW'(MAX_CYCLES - 1));

  // Next-state logic: IDLE -> RUN on start, RUN -> HALT on halt word or limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (halt_hit_s || timeout_hit_s) state_d = HALT;
        else                             state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // The pipe only carries fetches while RUN continues; leaving RUN drains it.
  assign flush_s = rst || (state_d != RUN);

`ifdef INSTR_ROM_STIM_TRACE_EN
  logic [DATA_W+31:0] pipe_in_s, pipe_out_s;
  logic [31:0]        pc_out_s;
  assign pipe_in_s  = {(run_s ? bus.IFPC : 32'h0000_0000), word_in_s};
  assign word_out_s = pipe_out_s[DATA_W-1:0];
  assign pc_out_s   = pipe_out_s[DATA_W+31:DATA_W];

  instr_rom_stim_pipe #(
    .WIDTH (DATA_W + 32),
    .LAT   (READ_LAT),
    .FILL  ({32'h0000_0000, FILL_WORD})
  ) u_pipe (
    .clk     (CLK),
    .flush_i (flush_s),
    .data_i  (pipe_in_s),
    .valid_i (run_s),
    .data_o  (pipe_out_s),
    .valid_o (valid_out_s)
  );

  logic [31:0]   last_pc_q;
  logic [CW-1:0] fetch_cnt_q;

  // Record the PC of each delivered fetch and count delivered fetches.
  always_ff @(posedge CLK) begin
    if (rst) begin
      last_pc_q   <= 32'h0000_0000;
      fetch_cnt_q <= {CW{1'b0}};
    end else if (valid_out_s) begin
      last_pc_q <= pc_out_s;
      if (fetch_cnt_q != {CW{1'b1}}) fetch_cnt_q <= fetch_cnt_q + CW'(1);
    end
  end

  assign last_pc   = last_pc_q;
  assign fetch_cnt = fetch_cnt_q;

`ifndef SYNTHESIS
  // Simulation-only fetch log.
  always @(posedge CLK) begin
    if (!rst && valid_out_s) $display("FETCH pc=%h data=%h", pc_out_s, word_out_s);
  end
`endif
`else
  instr_rom_stim_pipe #(
    .WIDTH (DATA_W),
    .LAT   (READ_LAT),
    .FILL  (FILL_WORD)
  ) u_pipe (
    .clk     (CLK),
    .flush_i (flush_s),
    .data_i  (word_in_s),
    .valid_i (run_s),
    .data_o  (word_out_s),
    .valid_o (valid_out_s)
  );
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Program image: cleared to FILL on reset, writable only while IDLE.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL_WORD;
    end else if ((state_q == IDLE) && bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Core reset, sticky end-of-run flags and the run-cycle counter.
  always_ff @(posedge CLK) begin
    if (rst) begin
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      oob_q        <= 1'b0;
      cycle_cnt_q  <= {CW{1'b0}};
    end else begin
      core_rst_n_q <= (state_d == RUN);
      if (run_s) begin
        if (cycle_cnt_q != {CW{1'b1}}) cycle_cnt_q <= cycle_cnt_q + CW'(1);
        if (fetch_oob_s) oob_q <= 1'b1;
        // A halt word seen in the same cycle as the limit is a normal halt.
        if (halt_hit_s) begin
          done_q <= 1'b1;
        end else if (timeout_hit_s) begin
          done_q    <= 1'b1;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ROMData    = word_out_s;
  assign bus.rom_valid  = valid_out_s;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.oob        = oob_q;
  assign bus.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_instr_rom_stim.sv
// Directed bench for instr_rom_stim: three instances (READ_LAT 0, 1, 3,
// MAX_CYCLES 16) driven with identical stimulus.
module tb_instr_rom_stim;
  localparam logic [31:0] FILL = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] WA   = 32'h0c84_8493;
  localparam logic [31:0] WB   = 32'h00a0_0593;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] fpc   [7];
  logic [31:0] fword [7];

  instr_rom_stim_if #(.DATA_W(32), .AW(8), .CW(16)) b0 ();
  instr_rom_stim_if #(.DATA_W(32), .AW(8), .CW(16)) b1 ();
  instr_rom_stim_if #(.DATA_W(32), .AW(8), .CW(16)) b3 ();

`ifdef INSTR_ROM_STIM_TRACE_EN
  logic [31:0] lp0, lp1, lp3;
  logic [15:0] fc0, fc1, fc3;
`endif

  instr_rom_stim #(.DATA_W(32), .DEPTH(256), .READ_LAT(0), .MAX_CYCLES(16), .CW(16)) dut0 (
    .CLK(clk), .rst(rst), .bus(b0.slave)
`ifdef INSTR_ROM_STIM_TRACE_EN
    , .last_pc(lp0), .fetch_cnt(fc0)
`endif
  );
  instr_rom_stim #(.DATA_W(32), .DEPTH(256), .READ_LAT(1), .MAX_CYCLES(16), .CW(16)) dut1 (
    .CLK(clk), .rst(rst), .bus(b1.slave)
`ifdef INSTR_ROM_STIM_TRACE_EN
    , .last_pc(lp1), .fetch_cnt(fc1)
`endif
  );
  instr_rom_stim #(.DATA_W(32), .DEPTH(256), .READ_LAT(3), .MAX_CYCLES(16), .CW(16)) dut3 (
    .CLK(clk), .rst(rst), .bus(b3.slave)
`ifdef INSTR_ROM_STIM_TRACE_EN
    , .last_pc(lp3), .fetch_cnt(fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] addr, input logic [31:0] data,
                       input logic st, input logic [31:0] pc);
    b0.prog_we = we; b0.prog_addr = addr; b0.prog_data = data; b0.start = st; b0.IFPC = pc;
    b1.prog_we = we; b1.prog_addr = addr; b1.prog_data = data; b1.start = st; b1.IFPC = pc;
    b3.prog_we = we; b3.prog_addr = addr; b3.prog_data = data; b3.start = st; b3.IFPC = pc;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fpc   = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd20, 32'd0, 32'd0};
    fword = '{WA, WA, WA, WA, WB, WA, WA};
    rst = 1'b1;
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk32("rst_romdata",  b1.ROMData, FILL);
    chk1 ("rst_valid",    b1.rom_valid, 1'b0);
    chk1 ("rst_core_rst", b1.core_rst_n, 1'b0);
    chk1 ("rst_done",     b1.done, 1'b0);
    chk1 ("rst_oob",      b1.oob, 1'b0);
    chk32("rst_cnt",      32'(b1.cycle_cnt), 32'd0);
    chk32("rst_romdata0", b0.ROMData, FILL);
    chk32("rst_romdata3", b3.ROMData, FILL);

    // Basic fetch with latency sweep
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), WA, 1'b0, 32'd0);
      tick();
    end
    drive(1'b1, 8'd5, WB, 1'b0, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b1, 32'd0);
    tick();
    chk1("start_core_rst_n", b1.core_rst_n, 1'b1);
    chk1("start_valid1",     b1.rom_valid, 1'b0);
    for (int j = 0; j < 7; j++) begin
      drive(1'b0, 8'd0, 32'd0, 1'b0, fpc[j]);
      #1;
      chk32("lat0_data",  b0.ROMData, fword[j]);
      chk1 ("lat0_valid", b0.rom_valid, 1'b1);
      tick();
      chk32("lat1_data",  b1.ROMData, fword[j]);
      chk1 ("lat1_valid", b1.rom_valid, 1'b1);
      if (j >= 2) begin
        chk32("lat3_data",  b3.ROMData, fword[j-2]);
        chk1 ("lat3_valid", b3.rom_valid, 1'b1);
      end else begin
        chk32("lat3_data_early",  b3.ROMData, FILL);
        chk1 ("lat3_valid_early", b3.rom_valid, 1'b0);
      end
    end
    chk32("run_cnt", 32'(b1.cycle_cnt), 32'd7);

    // Reset mid-run
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    chk1 ("midrst_core_rst", b1.core_rst_n, 1'b0);
    chk1 ("midrst_valid1",   b1.rom_valid, 1'b0);
    chk1 ("midrst_valid3",   b3.rom_valid, 1'b0);
    chk32("midrst_data1",    b1.ROMData, FILL);
    chk32("midrst_data0",    b0.ROMData, FILL);
    chk1 ("midrst_done",     b1.done, 1'b0);
    chk32("midrst_cnt",      32'(b1.cycle_cnt), 32'd0);
    rst = 1'b0;

    // Halt word (write and start in the same cycle)
    drive(1'b1, 8'd2, EBRK, 1'b1, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    #1;
    chk32("mem_cleared0", b0.ROMData, FILL);
    tick();
    chk32("mem_cleared1", b1.ROMData, FILL);
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd8);
    #1;
    chk32("halt_word0", b0.ROMData, EBRK);
    tick();
    chk1 ("halt_done0",    b0.done, 1'b1);
    chk1 ("halt_to0",      b0.timeout, 1'b0);
    chk1 ("halt_corerst0", b0.core_rst_n, 1'b0);
    chk1 ("halt_valid0",   b0.rom_valid, 1'b0);
    chk32("halt_word1",    b1.ROMData, EBRK);
    chk1 ("halt_wvalid1",  b1.rom_valid, 1'b1);
    chk1 ("halt_pre_done1", b1.done, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd12);
    tick();
    chk1 ("halt_done1",    b1.done, 1'b1);
    chk1 ("halt_to1",      b1.timeout, 1'b0);
    chk1 ("halt_corerst1", b1.core_rst_n, 1'b0);
    chk1 ("halt_valid1",   b1.rom_valid, 1'b0);
    chk32("halt_data1",    b1.ROMData, FILL);
    chk32("halt_cnt1",     32'(b1.cycle_cnt), 32'd3);
    tick();
    chk32("halt_word3",    b3.ROMData, EBRK);
    chk1 ("halt_pre_done3", b3.done, 1'b0);
    tick();
    chk1 ("halt_done3",    b3.done, 1'b1);
    chk1 ("halt_to3",      b3.timeout, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b1, 32'd12);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd12);
    tick();
    chk1 ("halt_restart_corerst", b1.core_rst_n, 1'b0);
    chk32("halt_frozen_cnt",      32'(b1.cycle_cnt), 32'd3);
    chk32("halt_frozen_cnt0",     32'(b0.cycle_cnt), 32'd2);

    // Timeout
    rst = 1'b1;
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'd0, 32'd0, 1'b1, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk1 ("to_pre_done", b1.done, 1'b0);
    chk32("to_pre_cnt",  32'(b1.cycle_cnt), 32'd15);
    tick();
    chk1 ("to_done",     b1.done, 1'b1);
    chk1 ("to_flag",     b1.timeout, 1'b1);
    chk32("to_cnt",      32'(b1.cycle_cnt), 32'd16);
    chk1 ("to_flag0",    b0.timeout, 1'b1);
    chk1 ("to_flag3",    b3.timeout, 1'b1);
    drive(1'b0, 8'd0, 32'd0, 1'b1, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk1 ("to_restart_corerst", b1.core_rst_n, 1'b0);
    chk1 ("to_restart_valid",   b1.rom_valid, 1'b0);
    chk32("to_restart_cnt",     32'(b1.cycle_cnt), 32'd16);
    chk1 ("to_restart_done",    b1.done, 1'b1);

    // Out of range: last word in range, one past it is not, sticky flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 8'd0, WA, 1'b0, 32'd0);
    tick();
    drive(1'b1, 8'd255, WB, 1'b0, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b1, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'h0000_03fc);
    #1;
    chk32("last_word0", b0.ROMData, WB);
    tick();
    chk32("last_word1", b1.ROMData, WB);
    chk1 ("last_oob",   b1.oob, 1'b0);
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'h0000_0400);
    #1;
    chk32("oob_data0",  b0.ROMData, FILL);
    tick();
    chk32("oob_data1",  b1.ROMData, FILL);
    chk1 ("oob_valid1", b1.rom_valid, 1'b1);
    chk1 ("oob_flag",   b1.oob, 1'b1);
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk32("oob_after_data", b1.ROMData, WA);
    chk1 ("oob_sticky",     b1.oob, 1'b1);

    // Out of range: misaligned
    rst = 1'b1;
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 8'd0, WA, 1'b1, 32'd0);
    tick();
    drive(1'b0, 8'd0, 32'd0, 1'b0, 32'h0000_0002);
    #1;
    chk32("misalign_data0", b0.ROMData, FILL);
    tick();
    chk32("misalign_data1", b1.ROMData, FILL);
    chk1 ("misalign_oob1",  b1.oob, 1'b1);
    chk1 ("misalign_oob0",  b0.oob, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
